// File: rtl/eth_udp_framer_if.sv
// Payload stream, transmit-BRAM write port and transmitter handshake
// between the UDP framer and its surroundings.
interface eth_udp_framer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bram_wr_en;
    logic [9:0]  bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] frame_count;

    modport master (
        input  in_data, in_valid, tx_busy,
        output in_ready, bram_wr_en, bram_wr_addr, bram_wr_data,
        output tx_start, frame_count
    );

    modport slave (
        output in_data, in_valid, tx_busy,
        input  in_ready, bram_wr_en, bram_wr_addr, bram_wr_data,
        input  tx_start, frame_count
    );
endinterface

// File: rtl/eth_udp_framer.sv
// Builds a fixed 526-byte Ethernet/IPv4/UDP frame into the transmit BRAM,
// then hands it to the 10BASE-T transmitter and waits for it to finish.
module eth_udp_framer #(
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC  = 48'h020000000001,
    parameter logic [31:0] SRC_IP   = 32'h0A000002,
    parameter logic [31:0] DST_IP   = 32'h0A000001,
    parameter logic [15:0] SRC_PORT = 16'd1234,
    parameter logic [15:0] DST_PORT = 16'd1234,
    parameter logic [7:0]  TTL      = 8'h40
) (
    input  logic               clk,
    input  logic               rst,
    eth_udp_framer_if.master   bus
);
    typedef enum logic [2:0] {
        CSUM, HDR, PAYLOAD, WAIT_IDLE, START, WAIT_DONE
    } state_t;

    state_t       state, state_n;
    logic [3:0]   cnt;
    logic [19:0]  sum;
    logic [16:0]  fold;
    logic [15:0]  word;
    logic [15:0]  csum;
    logic [15:0]  id;
    logic [15:0]  frame_count;
    logic [9:0]   ptr;
    logic         wr_en;
    logic [9:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         in_ready;
    logic         tx_start;
    logic [335:0] hdr;
    logic [5:0]   bidx;
    logic [7:0]   hdr_byte;

    assign hdr = {
        DST_MAC, SRC_MAC, 16'h0800,
        8'h45, 8'h00, 16'h0200, id, 16'h4000, TTL, 8'h11, csum,
        SRC_IP, DST_IP,
        SRC_PORT, DST_PORT, 16'h01EC, 16'h0000
    };

    assign bidx     = (ptr < 10'd42) ? ptr[5:0] : 6'd0;
    assign hdr_byte = hdr[{(6'd41 - bidx), 3'b000} +: 8];
    assign fold     = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};

    // IPv4 header words in order, checksum slot taken as zero
    always_comb begin
        word = 16'h0000;
        unique case (cnt)
            4'd0:    word = 16'h4500;
            4'd1:    word = 16'h0200;
            4'd2:    word = id;
            4'd3:    word = 16'h4000;
            4'd4:    word = {TTL, 8'h11};
            4'd5:    word = 16'h0000;
            4'd6:    word = SRC_IP[31:16];
            4'd7:    word = SRC_IP[15:0];
            4'd8:    word = DST_IP[31:16];
            4'd9:    word = DST_IP[15:0];
            default: word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CSUM;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        tx_start = 1'b0;
        unique case (state)
            CSUM:
                if (cnt == 4'd11) state_n = HDR;
            HDR:
                if (wr_addr == 10'd41) state_n = PAYLOAD;
            PAYLOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && ptr == 10'd525)
                    state_n = WAIT_IDLE;
            end
            WAIT_IDLE:
                if (!bus.tx_busy) state_n = START;
            // held until seen: the transmitter samples on its own strobe
            START:
                if (bus.tx_busy) state_n = WAIT_DONE;
                else             tx_start = 1'b1;
            WAIT_DONE:
                if (!bus.tx_busy) state_n = CSUM;
            default:
                state_n = CSUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 4'd0;
            sum         <= 20'd0;
            csum        <= 16'd0;
            id          <= 16'd0;
            frame_count <= 16'd0;
            ptr         <= 10'd0;
            wr_en       <= 1'b0;
            wr_addr     <= 10'd0;
            wr_data     <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                CSUM: begin
                    cnt <= cnt + 4'd1;
                    if (cnt < 4'd10) sum <= sum + {4'd0, word};
                    else             sum <= {3'd0, fold};
                    if (cnt == 4'd11) begin
                        csum    <= ~fold[15:0];
                        wr_en   <= 1'b1;
                        wr_addr <= 10'd0;
                        wr_data <= DST_MAC[47:40];
                        ptr     <= 10'd1;
                    end
                end
                HDR:
                    if (ptr != 10'd42) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= hdr_byte;
                        ptr     <= ptr + 10'd1;
                    end
                PAYLOAD:
                    if (bus.in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= bus.in_data;
                        ptr     <= ptr + 10'd1;
                    end
                START:
                    if (bus.tx_busy) frame_count <= frame_count + 16'd1;
                WAIT_DONE:
                    if (!bus.tx_busy) begin
                        id  <= id + 16'd1;
                        cnt <= 4'd0;
                        sum <= 20'd0;
                    end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.bram_wr_en   = wr_en;
    assign bus.bram_wr_addr = wr_addr;
    assign bus.bram_wr_data = wr_data;
    assign bus.tx_start     = tx_start;
    assign bus.frame_count  = frame_count;
endmodule
